// File: rtl/clk_meas_pkg.sv
// Shared types and helpers for the clock-measurement monitors.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } meas_state_t;

  localparam int unsigned CNT_W_DEF = 8;

  // Width needed to count 0..lock_cnt inclusive (never less than one bit).
  function automatic int unsigned lock_cnt_w(input int unsigned lock_cnt);
    return (lock_cnt < 1) ? 1 : $clog2(lock_cnt + 1);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus a delay flop for an asynchronous level,
// producing single-cycle rise/fall strobes in the clk domain.
module sync_edge_det (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // Synchronize din and keep one cycle of history for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/clk_div_meter.sv
// Measures high time, low time and period of a divided clock in source-clock
// cycles, flags a match against the expected ratio and declares lock after
// LOCK_CNT consecutive matches.
module clk_div_meter
  import clk_meas_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned EXP_N    = 7,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             div_clk,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] low_time,
  output logic [CNT_W:0]   period,
  output logic             meas_valid,
  output logic             match,
  output logic             lock,
  output logic             timeout
);

  localparam int unsigned     LCW       = lock_cnt_w(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W:0]   EXP_P    = (CNT_W+1)'(EXP_N);
  localparam logic [LCW-1:0]   LOCK_FULL = LCW'(LOCK_CNT);

  meas_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hold_high;
  logic [LCW-1:0]   lock_cnt;
  logic             rise, fall;
  logic [CNT_W:0]   period_nxt;
  logic             match_nxt;
  logic             saturated;

  sync_edge_det u_sync (
    .clk  (clk),
    .rstn (rstn),
    .din  (div_clk),
    .rise (rise),
    .fall (fall)
  );

  assign period_nxt = {1'b0, hold_high} + {1'b0, cnt};
  assign match_nxt  = (period_nxt == EXP_P);
  assign saturated  = (cnt == CNT_MAX);
  assign lock       = (lock_cnt == LOCK_FULL);

  // Measurement FSM: counts cycles per phase, publishes results on each
  // completed rise-fall-rise, and aborts to IDLE on counter saturation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      hold_high  <= '0;
      high_time  <= '0;
      low_time   <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      match      <= 1'b0;
      lock_cnt   <= '0;
      timeout    <= 1'b0;
    end else if (!en) begin
      state      <= IDLE;
      cnt        <= '0;
      lock_cnt   <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            cnt   <= CNT_ONE;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            hold_high <= cnt;
            cnt       <= CNT_ONE;
            state     <= LOW;
          end else if (saturated) begin
            timeout  <= 1'b1;
            match    <= 1'b0;
            lock_cnt <= '0;
            cnt      <= '0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            high_time  <= hold_high;
            low_time   <= cnt;
            period     <= period_nxt;
            meas_valid <= 1'b1;
            match      <= match_nxt;
            if (!match_nxt) begin
              lock_cnt <= '0;
            end else if (lock_cnt != LOCK_FULL) begin
              lock_cnt <= lock_cnt + 1'b1;
            end
            cnt   <= CNT_ONE;
            state <= HIGH;
          end else if (saturated) begin
            timeout  <= 1'b1;
            match    <= 1'b0;
            lock_cnt <= '0;
            cnt      <= '0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_meter.sv
// Scoreboard bench for clk_div_meter: expected measurements are queued as
// div_clk pairs are driven and popped when meas_valid pulses.
`timescale 1ns/1ps
module tb_clk_div_meter;

  localparam int CNT_W    = 8;
  localparam int EXP_N    = 7;
  localparam int LOCK_CNT = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             en = 1'b0;
  logic             div_clk = 1'b0;
  logic [CNT_W-1:0] high_time, low_time;
  logic [CNT_W:0]   period;
  logic             meas_valid, match, lock, timeout;

  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
    logic [8:0] per;
    logic       m;
    logic       lk;
  } meas_t;

  meas_t exp_q[$];
  meas_t got, want;
  int    errors = 0;
  int    checks = 0;
  int    mode = 0;          // 0: scoreboard, 1: asynchronous range check
  bit    allow_tmo = 1'b0;
  int    lock_model = 0;
  int    async_cnt = 0;
  int    async_sum = 0;

  clk_div_meter #(.CNT_W(CNT_W), .EXP_N(EXP_N), .LOCK_CNT(LOCK_CNT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .div_clk    (div_clk),
    .high_time  (high_time),
    .low_time   (low_time),
    .period     (period),
    .meas_valid (meas_valid),
    .match      (match),
    .lock       (lock),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish within 1ms");
    $fatal(1, "watchdog expired");
  end

  // Output monitor: compares every meas_valid against the scoreboard.
  always @(negedge clk) begin
    if (rstn && meas_valid) begin
      if (mode == 0) begin
        got.hi  = high_time;
        got.lo  = low_time;
        got.per = period;
        got.m   = match;
        got.lk  = lock;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_meas: got hi=%0d lo=%0d per=%0d, required no meas_valid",
                   high_time, low_time, period);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL meas: got hi=%0d lo=%0d per=%0d match=%0d lock=%0d, required hi=%0d lo=%0d per=%0d match=%0d lock=%0d",
                     got.hi, got.lo, got.per, got.m, got.lk,
                     want.hi, want.lo, want.per, want.m, want.lk);
          end
        end
      end else begin
        checks++;
        if (!(period === 9'd11 || period === 9'd12) || match !== 1'b0 || lock !== 1'b0) begin
          errors++;
          $display("FAIL async_period: got per=%0d match=%0d lock=%0d, required per 11 or 12 match=0 lock=0",
                   period, match, lock);
        end
        async_cnt++;
        async_sum += int'(period);
      end
    end
    if (rstn && timeout && !allow_tmo) begin
      checks++;
      errors++;
      $display("FAIL unexpected_timeout: got timeout=1, required 0");
    end
  end

  function automatic void push_exp(input int h, input int l);
    meas_t e;
    e.hi  = 8'(h);
    e.lo  = 8'(l);
    e.per = 9'(h + l);
    e.m   = ((h + l) == EXP_N);
    if (e.m) lock_model = (lock_model < LOCK_CNT) ? lock_model + 1 : LOCK_CNT;
    else     lock_model = 0;
    e.lk = (lock_model == LOCK_CNT);
    exp_q.push_back(e);
  endfunction

  // One rise-high-fall-low pair, starting and ending on a negedge.
  task automatic drive_pair(input int h, input int l, input bit push);
    div_clk = 1'b1;
    repeat (h) @(negedge clk);
    div_clk = 1'b0;
    repeat (l) @(negedge clk);
    if (push) push_exp(h, l);
  endtask

  task automatic restart();
    div_clk = 1'b0;
    en = 1'b0;
    repeat (4) @(negedge clk);
    en = 1'b1;
    lock_model = 0;
    @(negedge clk);
  endtask

  task automatic close_and_drain(input string name);
    div_clk = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending measurements, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    en = 1'b0;
    div_clk = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({high_time, low_time, period, meas_valid, match, lock, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got hi=%0d lo=%0d per=%0d mv=%0d m=%0d lk=%0d to=%0d, required all 0",
               high_time, low_time, period, meas_valid, match, lock, timeout);
    end
    rstn = 1'b1;
    en = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({high_time, low_time, period, meas_valid, match, lock, timeout} !== '0) begin
      errors++;
      $display("FAIL post_reset_outputs: got per=%0d mv=%0d lk=%0d, required all 0",
               period, meas_valid, lock);
    end
  endtask

  task automatic test_basic();
    restart();
    repeat (5) drive_pair(4, 3, 1'b1);
    div_clk = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (meas_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got meas_valid=%0d two cycles after rise, required 0", meas_valid);
    end
    @(negedge clk);
    checks++;
    if (meas_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: got meas_valid=%0d three cycles after rise, required 1", meas_valid);
    end
    @(negedge clk);
    checks++;
    if (lock !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_lock: got lock=%0d pending=%0d, required lock=1 pending=0", lock, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_mismatch();
    restart();
    repeat (5) drive_pair(4, 3, 1'b1);
    drive_pair(5, 3, 1'b1);
    repeat (4) drive_pair(4, 3, 1'b1);
    close_and_drain("mismatch");
    checks++;
    if (lock !== 1'b1) begin
      errors++;
      $display("FAIL relock: got lock=%0d, required 1", lock);
    end
  endtask

  task automatic test_enable();
    restart();
    repeat (4) drive_pair(4, 3, 1'b1);
    div_clk = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (lock !== 1'b1) begin
      errors++;
      $display("FAIL enable_prelock: got lock=%0d, required 1", lock);
    end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (lock !== 1'b0) begin
      errors++;
      $display("FAIL enable_lock_clear: got lock=%0d, required 0", lock);
    end
    repeat (2) @(negedge clk);
    div_clk = 1'b0;
    repeat (7) @(negedge clk);
    en = 1'b1;
    lock_model = 0;
    repeat (3) @(negedge clk);
    repeat (4) drive_pair(4, 3, 1'b1);
    close_and_drain("enable");
  endtask

  task automatic test_timeout();
    int n;
    restart();
    repeat (4) drive_pair(4, 3, 1'b1);
    allow_tmo = 1'b1;
    div_clk = 1'b1;
    n = 0;
    while (timeout !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 258) begin
      errors++;
      $display("FAIL timeout_latency: got timeout after %0d cycles, required 258", n);
    end
    @(negedge clk);
    checks++;
    if ({timeout, lock, match, period, high_time, low_time} !== {1'b0, 1'b0, 1'b0, 9'd7, 8'd4, 8'd3}) begin
      errors++;
      $display("FAIL timeout_state: got to=%0d lk=%0d m=%0d per=%0d hi=%0d lo=%0d, required to=0 lk=0 m=0 per=7 hi=4 lo=3",
               timeout, lock, match, period, high_time, low_time);
    end
    allow_tmo = 1'b0;
    lock_model = 0;
    div_clk = 1'b0;
    repeat (3) @(negedge clk);
    drive_pair(4, 3, 1'b1);
    close_and_drain("timeout");
  endtask

  task automatic test_async();
    restart();
    mode = 1;
    async_cnt = 0;
    async_sum = 0;
    #($urandom_range(0, 999) * 0.01 + 0.003);
    for (int i = 0; i < 30; i++) begin
      div_clk = 1'b1;
      #57.5;
      div_clk = 1'b0;
      #57.5;
    end
    repeat (5) @(negedge clk);
    mode = 0;
    checks++;
    if (async_cnt != 29) begin
      errors++;
      $display("FAIL async_count: got %0d measurements, required 29", async_cnt);
    end
    checks++;
    if (2 * async_sum - 23 * 29 > 2 || 2 * async_sum - 23 * 29 < -2) begin
      errors++;
      $display("FAIL async_average: got period sum %0d, required 333 or 334", async_sum);
    end
  endtask

  task automatic test_reset_mid();
    restart();
    drive_pair(4, 3, 1'b1);
    div_clk = 1'b1;
    repeat (4) @(negedge clk);
    div_clk = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if ({high_time, low_time, period, meas_valid, match, lock, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got hi=%0d lo=%0d per=%0d m=%0d lk=%0d, required all 0",
               high_time, low_time, period, match, lock);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    lock_model = 0;
    repeat (3) @(negedge clk);
    repeat (2) drive_pair(4, 3, 1'b1);
    close_and_drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mismatch();
    test_enable();
    test_timeout();
    test_async();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
